vrf_wr_arb: RTL and testbench
=============================

VRF_WR_ARB -- requirements
Module: vrf_wr_arb

Interface
REQ-001 Parameter NUM_WR_PORTS, default 8, number of write requesters.
REQ-002 Parameter DATA_SIZE, default 2048, vector datapath width in bits; strobe width is DATA_SIZE/8.
REQ-003 Parameter ADDR_W, default 5, vector register index width.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_valid  input  [NUM_WR_PORTS-1:0]  per-port write request.
REQ-007 wr_ready  output  [NUM_WR_PORTS-1:0]  per-port accept; transfer when valid&&ready.
REQ-008 wr_addr  input  [ADDR_W-1:0] x NUM_WR_PORTS  per-port destination register.
REQ-009 wr_data  input  [DATA_SIZE-1:0] x NUM_WR_PORTS  per-port write data.
REQ-010 wr_strb  input  [DATA_SIZE/8-1:0] x NUM_WR_PORTS  per-port byte strobe.
REQ-011 rf_wr_valid  output  1  registered write command to register file.
REQ-012 rf_ready  input  1  register file accepts command this cycle.
REQ-013 rf_wr_addr / rf_wr_data / rf_wr_strb  output  ADDR_W / DATA_SIZE / DATA_SIZE/8  winner command.
REQ-014 rf_wr_port  output  [$clog2(NUM_WR_PORTS)-1:0]  index of granted port.

Function
REQ-015 FSM states IDLE (output register empty), BUSY (output register holds a command, rf_ready high or unknown), STALL (command held, rf_ready low last cycle).
REQ-016 IDLE -> BUSY when any wr_valid high; BUSY -> STALL when rf_ready low; STALL -> BUSY when rf_ready high and a new request is captured; BUSY/STALL -> IDLE when rf_ready high and no wr_valid.
REQ-017 Output register is loadable when empty or when rf_ready high (full-throughput, one command per cycle).
REQ-018 When loadable, grant exactly one port: first valid port at or after rr_ptr, searching upward with wrap from NUM_WR_PORTS-1 to 0.
REQ-019 wr_ready is one-hot (granted port only) when loadable, all-zero otherwise; never depends on a port's own wr_valid combinationally beyond grant selection.
REQ-020 On grant of port g, rr_ptr <= (g+1) mod NUM_WR_PORTS; rr_ptr unchanged when no grant.
REQ-021 Latency: request accepted in cycle N appears on rf_wr_* in cycle N+1.
REQ-022 While rf_wr_valid high and rf_ready low, rf_wr_* hold stable and all wr_ready are 0.
REQ-023 Request with wr_strb all-zero is accepted (ready pulses) but not forwarded; rf_wr_valid not set for it, rr_ptr still advances.
REQ-024 Any port with wr_valid continuously high is granted within NUM_WR_PORTS accepting cycles (no starvation).
REQ-025 Requests to same wr_addr from different ports are serialised in grant order; no merging.

Reset
REQ-026 On rst_n low: state IDLE, rr_ptr 0, rf_wr_valid 0, rf_wr_addr 0, rf_wr_data 0, rf_wr_strb 0, rf_wr_port 0, wr_ready 0.
REQ-027 Reset asserted mid-STALL discards the held command; no write issued after deassertion.
REQ-028 First grant possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro VRF_WR_ARB_PERF_EN defined: extra outputs conflict_cnt [31:0] (cycles with more than one wr_valid while loadable) and stall_cnt [31:0] (cycles in STALL), both saturating, reset to 0.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 Package vrf_pkg holds DATA_SIZE/ADDR_W defaults, the FSM state enum and the write-command struct (addr, data, strb, port).
REQ-032 One sub-module rr_arbiter (request vector + pointer in, one-hot grant + index out, combinational) is instantiated once.

Verification
REQ-033 Reset: all outputs 0 after rst_n low; no rf_wr_valid for 3 idle cycles after release.
REQ-034 Ports 0,3,7 valid continuously, rf_ready=1 -> rf_wr_port sequence 0,3,7,0,3,7, one per cycle.
REQ-035 rr_ptr=7, ports 7 and 0 valid -> port 7 granted, then port 0 (wrap).
REQ-036 Port 2 writes addr 5 data 0xA5.., rf_ready low 4 cycles -> rf_wr_* stable 4 cycles, wr_ready all 0, written once on release.
REQ-037 Port 4 strobe 0 -> wr_ready[4] pulses, rf_wr_valid stays 0.
REQ-038 rst_n low during STALL -> command dropped, rf_wr_valid 0; with VRF_WR_ARB_PERF_EN, stall_cnt and conflict_cnt return to 0.

Source files
------------

// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared defaults, FSM state and write-command type for the VRF write arbiter
package vrf_pkg;

  localparam int VRF_NUM_WR_PORTS = 8;
  localparam int VRF_DATA_SIZE    = 2048;
  localparam int VRF_ADDR_W       = 5;
  localparam int VRF_PORT_W       = $clog2(VRF_NUM_WR_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_STALL = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [VRF_ADDR_W-1:0]      addr;
    logic [VRF_DATA_SIZE-1:0]   data;
    logic [VRF_DATA_SIZE/8-1:0] strb;
    logic [VRF_PORT_W-1:0]      port;
  } wr_cmd_t;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vrf_wr_arb_rr_arbiter.sv
// rtl/vrf_wr_arb_rr_arbiter.sv - combinational round-robin grant: first request at or above ptr, with wrap
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr} + (IW+1)'(i);
      if (k >= (IW+1)'(N)) begin
        k = k - (IW+1)'(N);
      end
      if (!gnt_vld && req[k[IW-1:0]]) begin
        gnt_vld           = 1'b1;
        gnt[k[IW-1:0]]    = 1'b1;
        gnt_idx           = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/vrf_wr_arb.sv
// rtl/vrf_wr_arb.sv - N-port round-robin vector register file write arbiter; VRF_WR_ARB_PERF_EN adds perf counters
module vrf_wr_arb
  import vrf_pkg::*;
#(
  parameter int NUM_WR_PORTS = VRF_NUM_WR_PORTS,
  parameter int DATA_SIZE    = VRF_DATA_SIZE,
  parameter int ADDR_W       = VRF_ADDR_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_WR_PORTS-1:0]                   wr_valid,
  output logic [NUM_WR_PORTS-1:0]                   wr_ready,
  input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]       wr_addr,
  input  logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0]    wr_data,
  input  logic [NUM_WR_PORTS-1:0][DATA_SIZE/8-1:0]  wr_strb,
  output logic                                      rf_wr_valid,
  input  logic                                      rf_ready,
  output logic [ADDR_W-1:0]                         rf_wr_addr,
  output logic [DATA_SIZE-1:0]                      rf_wr_data,
  output logic [DATA_SIZE/8-1:0]                    rf_wr_strb,
  output logic [$clog2(NUM_WR_PORTS)-1:0]           rf_wr_port
`ifdef VRF_WR_ARB_PERF_EN
  ,
  output logic [31:0]                               conflict_cnt,
  output logic [31:0]                               stall_cnt
`endif
);

  localparam int PORT_W = $clog2(NUM_WR_PORTS);
  localparam int STRB_W = DATA_SIZE / 8;

  arb_state_e            state_q, state_d;
  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]     rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_SIZE-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic [STRB_W-1:0]     rf_wr_strb_q, rf_wr_strb_d;
  logic [PORT_W-1:0]     rf_wr_port_q, rf_wr_port_d;

  logic [NUM_WR_PORTS-1:0] gnt;
  logic [PORT_W-1:0]       gnt_idx;
  logic                    gnt_vld;
  logic                    loadable;
  logic                    accept;
  logic                    fwd;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_SIZE-1:0]    sel_data;
  logic [STRB_W-1:0]       sel_strb;

  rr_arbiter #(
    .N  (NUM_WR_PORTS),
    .IW (PORT_W)
  ) u_rr_arbiter (
    .req     (wr_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign sel_addr = wr_addr[gnt_idx];
  assign sel_data = wr_data[gnt_idx];
  assign sel_strb = wr_strb[gnt_idx];
  assign accept   = loadable && gnt_vld;
  // A grant with an all-zero strobe is consumed here and never reaches the register file.
  assign fwd      = |sel_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && fwd) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY, ST_STALL: begin
        if (!rf_ready) begin
          state_d = ST_STALL;
        end else if (accept && fwd) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_wr_valid = (state_q != ST_IDLE);
    loadable    = (state_q == ST_IDLE) || rf_ready;
    wr_ready    = (loadable && rst_n) ? gnt : '0;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_strb_d = rf_wr_strb_q;
    rf_wr_port_d = rf_wr_port_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == PORT_W'(NUM_WR_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);
      if (fwd) begin
        rf_wr_addr_d = sel_addr;
        rf_wr_data_d = sel_data;
        rf_wr_strb_d = sel_strb;
        rf_wr_port_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      rf_wr_strb_q <= '0;
      rf_wr_port_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_strb_q <= rf_wr_strb_d;
      rf_wr_port_q <= rf_wr_port_d;
    end
  end

  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_wr_strb = rf_wr_strb_q;
  assign rf_wr_port = rf_wr_port_q;

`ifdef VRF_WR_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        multi_valid;

  always_comb begin
    // Clearing the lowest set bit leaves something only when two or more requests are up.
    multi_valid    = |(wr_valid & (wr_valid - NUM_WR_PORTS'(1)));
    conflict_cnt_d = (loadable && multi_valid) ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
    stall_cnt_d    = (state_q == ST_STALL) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vrf_wr_arb.sv
// tb/tb_vrf_wr_arb.sv - scoreboard bench for vrf_wr_arb with a queue-based reference model
module tb_vrf_wr_arb;
  import vrf_pkg::*;

  localparam int N  = VRF_NUM_WR_PORTS;
  localparam int DW = VRF_DATA_SIZE;
  localparam int SW = DW / 8;
  localparam int AW = VRF_ADDR_W;
  localparam int PW = VRF_PORT_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N-1:0]            wr_valid;
  logic [N-1:0]            wr_ready;
  logic [N-1:0][AW-1:0]    wr_addr;
  logic [N-1:0][DW-1:0]    wr_data;
  logic [N-1:0][SW-1:0]    wr_strb;
  logic                    rf_wr_valid;
  logic                    rf_ready;
  logic [AW-1:0]           rf_wr_addr;
  logic [DW-1:0]           rf_wr_data;
  logic [SW-1:0]           rf_wr_strb;
  logic [PW-1:0]           rf_wr_port;
`ifdef VRF_WR_ARB_PERF_EN
  logic [31:0]             conflict_cnt;
  logic [31:0]             stall_cnt;
`endif

  always #5 clk = ~clk;

  vrf_wr_arb #(
    .NUM_WR_PORTS (N),
    .DATA_SIZE    (DW),
    .ADDR_W       (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .rf_wr_valid  (rf_wr_valid),
    .rf_ready     (rf_ready),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .rf_wr_strb   (rf_wr_strb),
    .rf_wr_port   (rf_wr_port)
`ifdef VRF_WR_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  int      n_checks = 0;
  int      n_pass   = 0;
  bit      in_reset = 1'b1;
  bit      a5_mode  = 1'b0;
  int      ptr      = 0;
  wr_cmd_t exp_q[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(rf_wr_valid === 1'b0, {tag, " rf_wr_valid"}, 64'(rf_wr_valid), 64'd0);
    check(rf_wr_addr === '0 && rf_wr_port === '0, {tag, " rf_wr_addr/port"}, 64'({rf_wr_addr, rf_wr_port}), 64'd0);
    check(rf_wr_data === '0 && rf_wr_strb === '0, {tag, " rf_wr_data/strb"}, rf_wr_data[63:0], 64'd0);
    check(wr_ready === '0, {tag, " wr_ready"}, 64'(wr_ready), 64'd0);
`ifdef VRF_WR_ARB_PERF_EN
    check(conflict_cnt === 32'd0, {tag, " conflict_cnt"}, 64'(conflict_cnt), 64'd0);
    check(stall_cnt === 32'd0, {tag, " stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  task automatic randomize_port(input int p, input bit zero_strb);
    wr_addr[p] = AW'($urandom);
    for (int w = 0; w < DW / 32; w++) wr_data[p][w*32 +: 32] = $urandom;
    for (int w = 0; w < SW / 32; w++) wr_strb[p][w*32 +: 32] = $urandom;
    if (zero_strb) wr_strb[p] = '0;
    else if (wr_strb[p] == '0) wr_strb[p][$urandom_range(0, SW-1)] = 1'b1;
  endtask

  // Reference: a command register that is either empty or holds the oldest accepted,
  // forwarded request; a new grant is only possible once that slot is (being) drained.
  task automatic model_step();
    int           g;
    logic [N-1:0] exp_rdy;
    wr_cmd_t      c;
    g       = -1;
    exp_rdy = '0;
    if (exp_q.size() == 0) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && wr_valid[(ptr + i) % N]) g = (ptr + i) % N;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check(wr_ready === exp_rdy, "wr_ready", 64'(wr_ready), 64'(exp_rdy));
    if (g >= 0) begin
      ptr = (g + 1) % N;
      if (wr_strb[g] != '0) begin
        c.addr = wr_addr[g];
        c.data = wr_data[g];
        c.strb = wr_strb[g];
        c.port = PW'(g);
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input bit rdy, input logic [N-1:0] zmask);
    @(negedge clk);
    for (int p = 0; p < N; p++) randomize_port(p, zmask[p]);
    if (a5_mode) begin
      wr_addr[2] = AW'(5);
      wr_data[2] = {SW{8'hA5}};
    end
    wr_valid = v;
    rf_ready = rdy;
    #2;
    model_step();
  endtask

  initial begin : monitor
    bit ev;
    forever begin
      @(negedge clk);
      #1;
      if (!in_reset) begin
        ev = (exp_q.size() != 0);
        check(rf_wr_valid === ev, "rf_wr_valid", 64'(rf_wr_valid), 64'(ev));
        if (ev) begin
          check(rf_wr_addr === exp_q[0].addr && rf_wr_port === exp_q[0].port, "rf_wr_addr/port",
                64'({rf_wr_addr, rf_wr_port}), 64'({exp_q[0].addr, exp_q[0].port}));
          check(rf_wr_data === exp_q[0].data && rf_wr_strb === exp_q[0].strb, "rf_wr_data/strb",
                rf_wr_data[63:0], exp_q[0].data[63:0]);
          if (rf_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] v;
    logic [N-1:0] z;
    bit           rdy;
    rst_n    = 1'b0;
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;
    rf_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    repeat (3) cycle('0, 1'b1, '0);

    repeat (9) cycle(8'b1000_1001, 1'b1, '0);
    cycle('0, 1'b1, '0);

    cycle(8'h40, 1'b1, '0);
    repeat (2) cycle(8'h81, 1'b1, '0);
    cycle('0, 1'b1, '0);

    a5_mode = 1'b1;
    cycle(8'h04, 1'b1, '0);
    repeat (4) cycle(8'hFF, 1'b0, '0);
    cycle('0, 1'b1, '0);
    a5_mode = 1'b0;
    repeat (2) cycle('0, 1'b1, '0);

    cycle(8'h10, 1'b1, 8'h10);
    repeat (2) cycle('0, 1'b1, '0);

    cycle(8'h02, 1'b1, '0);
    repeat (2) cycle(8'h0F, 1'b0, '0);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    wr_valid = '0;
    exp_q.delete();
    ptr = 0;
    #1;
    check_reset_outputs("mid_stall_reset");
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    repeat (3) cycle('0, 1'b1, '0);

    repeat (400) begin
      v = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      z   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      cycle(v, rdy, z);
    end
    repeat (3) cycle('0, 1'b1, '0);
    check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
